// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and resolve-side update bundle for branch_predictor.
// The predictor is the slave; the fetch/execute logic driving it is the master.
interface branch_predictor_if;
  logic        enable;
  logic [31:0] fetchPc;
  logic        updateValid;
  logic [31:0] updatePc;
  logic        updateTaken;
  logic [31:0] updateTarget;
  logic        predicted;
  logic [31:0] predictedPc;
  logic [31:0] lookupHits;
  logic [31:0] mispredicts;

  // updateValid has no ready: an update is consumed on every enabled clock edge it is high.
  modport master (
    output enable, fetchPc, updateValid, updatePc, updateTaken, updateTarget,
    input  predicted, predictedPc, lookupHits, mispredicts
  );

  modport slave (
    input  enable, fetchPc, updateValid, updatePc, updateTaken, updateTarget,
    output predicted, predictedPc, lookupHits, mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Define BRANCH_PREDICTOR_STATS_EN to build the lookupHits/mispredicts counters.
module branch_predictor #(
  parameter int INDEX_BITS = 3
) (
  input  logic               clock,
  input  logic               reset,
  branch_predictor_if.slave  bus
);
  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic [ENTRIES-1:0]  valid_q;
  logic [1:0]          ctr_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0]   fetch_tag;
  logic                  fetch_hit;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  upd_hit;
  logic                  do_update;

  assign fetch_idx = bus.fetchPc[INDEX_BITS+1:2];
  assign fetch_tag = bus.fetchPc[31:INDEX_BITS+2];
  assign upd_idx   = bus.updatePc[INDEX_BITS+1:2];
  assign upd_tag   = bus.updatePc[31:INDEX_BITS+2];
  assign do_update = bus.updateValid && bus.enable;

  // Lookup reads the registered table only, so a same-cycle update is seen next cycle.
  always_comb begin
    fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    bus.predicted   = fetch_hit && ctr_q[fetch_idx][1];
    bus.predictedPc = bus.fetchPc + 32'd4;
    if (bus.predicted) begin
      bus.predictedPc = target_q[fetch_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= 2'd0;
      end
    end else if (do_update) begin
      if (upd_hit) begin
        if (bus.updateTaken && (ctr_q[upd_idx] != 2'd3)) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
        end else if (!bus.updateTaken && (ctr_q[upd_idx] != 2'd0)) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
      end else if (bus.updateTaken) begin
        valid_q[upd_idx] <= 1'b1;
        ctr_q[upd_idx]   <= 2'd2;
      end
    end
  end

  // Tag and target carry no reset; valid_q alone decides whether they mean anything.
  always_ff @(posedge clock) begin
    if (!reset && do_update && bus.updateTaken) begin
      target_q[upd_idx] <= bus.updateTarget;
      if (!upd_hit) begin
        tag_q[upd_idx] <= upd_tag;
      end
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] hits_q;
  logic [31:0] mispredicts_q;
  logic        upd_pred;

  assign upd_pred = upd_hit && ctr_q[upd_idx][1];

  always_ff @(posedge clock) begin
    if (reset) begin
      hits_q        <= '0;
      mispredicts_q <= '0;
    end else if (do_update) begin
      if (upd_hit) begin
        hits_q <= hits_q + 32'd1;
      end
      if (upd_pred != bus.updateTaken) begin
        mispredicts_q <= mispredicts_q + 32'd1;
      end
    end
  end

  assign bus.lookupHits  = hits_q;
  assign bus.mispredicts = mispredicts_q;
`else
  assign bus.lookupHits  = '0;
  assign bus.mispredicts = '0;
`endif
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter INDEX_BITS, default 3; entry count = 2**INDEX_BITS, direct-mapped.
REQ-002 clock  input  1  single clock; all state updates on posedge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 enable  input  1  update/stat gating; low freezes all state.
REQ-005 fetchPc  input  32  PC currently being fetched, lookup address.
REQ-006 updateValid  input  1  a resolved conditional branch is presented this cycle.
REQ-007 updatePc  input  32  PC of the resolved branch.
REQ-008 updateTaken  input  1  resolved direction, 1 = taken.
REQ-009 updateTarget  input  32  resolved branch destination.
REQ-010 predicted  output  1  lookup predicts taken for fetchPc.
REQ-011 predictedPc  output  32  next fetch address: stored target if predicted, else fetchPc + 4.
REQ-012 lookupHits  output  32  count of updates whose PC hit a valid entry.
REQ-013 mispredicts  output  32  count of updates whose recorded prediction disagreed with updateTaken.

Function
REQ-014 Index = PC[INDEX_BITS+1:2]; tag = PC[31:INDEX_BITS+2]; PC[1:0] ignored.
REQ-015 Each entry SHALL hold valid (1b), tag, target (32b), 2-bit saturating counter.
REQ-016 Lookup SHALL be combinational, zero latency: hit = valid && tag match at fetchPc index.
REQ-017 predicted SHALL be 1 only when hit && counter >= 2; predictedPc SHALL be fetchPc + 4 (mod 2**32) otherwise.
REQ-018 Update SHALL occur on posedge when updateValid && enable && !reset.
REQ-019 Update hit: counter +1 saturating at 3 if updateTaken, -1 saturating at 0 otherwise; target overwritten with updateTarget only when taken.
REQ-020 Update miss, taken: allocate entry (valid=1, new tag, target=updateTarget, counter=2), evicting any prior occupant.
REQ-021 Update miss, not taken: no entry change.
REQ-022 Lookup and update to the same index in the same cycle: lookup SHALL return pre-update contents; new contents visible next cycle.
REQ-023 Update-time prediction = (hit && counter >= 2) evaluated on pre-update contents at updatePc; mispredict = that value != updateTaken.
REQ-024 Stat counters SHALL increment by 1 per qualifying update and wrap 0xFFFFFFFF -> 0.
REQ-025 enable low: no entry or counter change; lookup outputs remain live.

Reset
REQ-026 reset SHALL clear every valid bit and counter to 0 and zero lookupHits and mispredicts; it dominates enable and updateValid.
REQ-027 During and after reset, predicted = 0 and predictedPc = fetchPc + 4 until a taken update allocates an entry.
REQ-028 Target and tag storage need not be cleared by reset.

Configuration
REQ-029 Macro BRANCH_PREDICTOR_STATS_EN defined: lookupHits and mispredicts implemented per REQ-012/013/023/024.
REQ-030 Macro undefined: no counter registers built; lookupHits and mispredicts tied to 0; prediction behaviour unchanged.

Verification
REQ-031 Reset, fetchPc=0x100 -> predicted=0, predictedPc=0x104.
REQ-032 Update PC 0x100 taken, target 0x200, then fetchPc=0x100 -> predicted=1, predictedPc=0x200; mispredicts=1.
REQ-033 Two not-taken updates at 0x100 after REQ-032 -> counter 0, predicted=0, predictedPc=0x104; four taken updates -> counter saturates at 3, one not-taken still predicts taken.
REQ-034 Entry at 0x100 (counter 2), taken update at 0x120 (same index, INDEX_BITS=3) -> fetchPc=0x100 misses (predictedPc=0x104); fetchPc=0x120 hits.
REQ-035 fetchPc=updatePc=0x100 same cycle, first taken update -> predicted=0 that cycle, 1 next cycle; enable=0 with updateValid=1 -> no state change.
REQ-036 With BRANCH_PREDICTOR_STATS_EN, mispredicts preloaded to 0xFFFFFFFF via forced updates -> wraps to 0; without macro both stat outputs stay 0 throughout.
